// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - microcoded-style step sequencer emitting bus/register control strobes
module cpu_controller (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] opcode,
  input  logic       carry_flag,
  input  logic       zero_flag,
  output logic       c,
  output logic       ep,
  output logic       lp,
  output logic       lm,
  output logic       er,
  output logic       we,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       lb,
  output logic       eu,
  output logic       su,
  output logic       fl,
  output logic       lo,
  output logic       hlt,
  output logic [2:0] t_state
);

  localparam logic [2:0] ST_T0   = 3'd0;
  localparam logic [2:0] ST_T1   = 3'd1;
  localparam logic [2:0] ST_T2   = 3'd2;
  localparam logic [2:0] ST_T3   = 3'd3;
  localparam logic [2:0] ST_T4   = 3'd4;
  localparam logic [2:0] ST_HALT = 3'd7;

  localparam logic [3:0] OP_LDA = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0011;
  localparam logic [3:0] OP_STA = 4'b0100;
  localparam logic [3:0] OP_LDI = 4'b0101;
  localparam logic [3:0] OP_JMP = 4'b0110;
  localparam logic [3:0] OP_JC  = 4'b0111;
  localparam logic [3:0] OP_JZ  = 4'b1000;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  logic [2:0] state;
  logic [2:0] state_next;

  assign t_state = state;

  // State register: async clear to T0, advances only while enabled
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_T0;
    end else if (en) begin
      state <= state_next;
    end
  end

  // Next step: fetch is fixed, each instruction returns to T0 right after its last step
  always_comb begin
    state_next = ST_T0;
    case (state)
      ST_T0: state_next = ST_T1;
      ST_T1: state_next = ST_T2;
      ST_T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: state_next = ST_T3;
          OP_HLT:                         state_next = ST_HALT;
          default:                        state_next = ST_T0;
        endcase
      end
      ST_T3: begin
        if (opcode == OP_ADD || opcode == OP_SUB) state_next = ST_T4;
        else                                      state_next = ST_T0;
      end
      ST_T4:   state_next = ST_T0;
      ST_HALT: state_next = ST_HALT;
      default: state_next = ST_T0;
    endcase
  end

  // Control decode; everything is gated by rst so reset silences outputs without a clock
  always_comb begin
    c   = 1'b0;
    ep  = 1'b0;
    lp  = 1'b0;
    lm  = 1'b0;
    er  = 1'b0;
    we  = 1'b0;
    li  = 1'b0;
    ei  = 1'b0;
    la  = 1'b0;
    ea  = 1'b0;
    lb  = 1'b0;
    eu  = 1'b0;
    su  = 1'b0;
    fl  = 1'b0;
    lo  = 1'b0;
    hlt = 1'b0;
    if (rst) begin
      hlt = (state == ST_HALT);
      if (en) begin
        case (state)
          ST_T0: begin
            ep = 1'b1;
            lm = 1'b1;
          end
          ST_T1: begin
            er = 1'b1;
            li = 1'b1;
            c  = 1'b1;
          end
          ST_T2: begin
            case (opcode)
              OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                ei = 1'b1;
                lm = 1'b1;
              end
              OP_LDI: begin
                ei = 1'b1;
                la = 1'b1;
              end
              OP_JMP: begin
                ei = 1'b1;
                lp = 1'b1;
              end
              OP_JC: begin
                ei = carry_flag;
                lp = carry_flag;
              end
              OP_JZ: begin
                ei = zero_flag;
                lp = zero_flag;
              end
              OP_OUT: begin
                ea = 1'b1;
                lo = 1'b1;
              end
              default: ;
            endcase
          end
          ST_T3: begin
            if (opcode == OP_STA) begin
              ea = 1'b1;
              we = 1'b1;
            end else begin
              er = 1'b1;
              if (opcode == OP_LDA) la = 1'b1;
              else                  lb = 1'b1;
            end
          end
          ST_T4: begin
            eu = 1'b1;
            la = 1'b1;
            fl = 1'b1;
            su = (opcode == OP_SUB);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - directed and random self-checking bench for cpu_controller
module tb_cpu_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic [3:0] opcode = 4'd0;
  logic       carry_flag = 1'b0;
  logic       zero_flag = 1'b0;
  logic c, ep, lp, lm, er, we, li, ei, la, ea, lb, eu, su, fl, lo, hlt;
  logic [2:0] t_state;

  int passed = 0;
  int total = 0;

  localparam logic [14:0] C_  = 15'h4000;
  localparam logic [14:0] EP_ = 15'h2000;
  localparam logic [14:0] LP_ = 15'h1000;
  localparam logic [14:0] LM_ = 15'h0800;
  localparam logic [14:0] ER_ = 15'h0400;
  localparam logic [14:0] WE_ = 15'h0200;
  localparam logic [14:0] LI_ = 15'h0100;
  localparam logic [14:0] EI_ = 15'h0080;
  localparam logic [14:0] LA_ = 15'h0040;
  localparam logic [14:0] EA_ = 15'h0020;
  localparam logic [14:0] LB_ = 15'h0010;
  localparam logic [14:0] EU_ = 15'h0008;
  localparam logic [14:0] SU_ = 15'h0004;
  localparam logic [14:0] FL_ = 15'h0002;
  localparam logic [14:0] LO_ = 15'h0001;

  logic [14:0] ctl;
  assign ctl = {c, ep, lp, lm, er, we, li, ei, la, ea, lb, eu, su, fl, lo};

  cpu_controller dut (
    .clk(clk), .rst(rst), .en(en), .opcode(opcode),
    .carry_flag(carry_flag), .zero_flag(zero_flag),
    .c(c), .ep(ep), .lp(lp), .lm(lm), .er(er), .we(we), .li(li), .ei(ei),
    .la(la), .ea(ea), .lb(lb), .eu(eu), .su(su), .fl(fl), .lo(lo),
    .hlt(hlt), .t_state(t_state)
  );

  always #5 clk = ~clk;

  // Asynchronous reset pulse placed mid low-phase, leaves the DUT in T0 before the next rising edge
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #2;
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; opcode = 4'b0001;
    @(negedge clk);
    #1;
    total++;
    if (t_state !== 3'd0 || ctl !== 15'h0 || hlt !== 1'b0)
      $display("FAIL reset_hold: state=%0d ctl=%h hlt=%b required state=0 ctl=0000 hlt=0", t_state, ctl, hlt);
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if (t_state !== 3'd0 || ctl !== 15'h0)
      $display("FAIL reset_clocked: state=%0d ctl=%h required state=0 ctl=0000", t_state, ctl);
    else passed++;
    rst = 1'b1;
    #1;
    total++;
    if (t_state !== 3'd0 || ctl !== (EP_ | LM_))
      $display("FAIL reset_release_t0: state=%0d ctl=%h required state=0 ctl=%h", t_state, ctl, EP_ | LM_);
    else passed++;
  endtask

  task automatic test_lda_sta();
    logic [14:0] lda_ctl [5] = '{EP_|LM_, ER_|LI_|C_, EI_|LM_, ER_|LA_, EP_|LM_};
    logic [14:0] sta_ctl [5] = '{EP_|LM_, ER_|LI_|C_, EI_|LM_, EA_|WE_, EP_|LM_};
    logic [2:0]  st [5]      = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
    for (int k = 0; k < 2; k++) begin
      en = 1'b1;
      opcode = (k == 0) ? 4'b0001 : 4'b0100;
      do_reset();
      for (int i = 0; i < 5; i++) begin
        #1;
        total++;
        if (t_state !== st[i] || ctl !== ((k == 0) ? lda_ctl[i] : sta_ctl[i]))
          $display("FAIL %s_cycle%0d: state=%0d ctl=%h required state=%0d ctl=%h",
                   (k == 0) ? "lda" : "sta", i, t_state, ctl, st[i], (k == 0) ? lda_ctl[i] : sta_ctl[i]);
        else passed++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_add_sub();
    logic [14:0] exp_ctl [6];
    logic [2:0]  st [6] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd0};
    for (int k = 0; k < 2; k++) begin
      exp_ctl = '{EP_|LM_, ER_|LI_|C_, EI_|LM_, ER_|LB_,
                  (k == 0) ? (EU_|LA_|FL_) : (EU_|SU_|LA_|FL_), EP_|LM_};
      en = 1'b1;
      opcode = (k == 0) ? 4'b0010 : 4'b0011;
      do_reset();
      for (int i = 0; i < 6; i++) begin
        #1;
        total++;
        if (t_state !== st[i] || ctl !== exp_ctl[i])
          $display("FAIL %s_cycle%0d: state=%0d ctl=%h required state=%0d ctl=%h",
                   (k == 0) ? "add" : "sub", i, t_state, ctl, st[i], exp_ctl[i]);
        else passed++;
        @(negedge clk);
      end
    end
  endtask

  // Conditional jumps: flags only matter in T2; in T0/T1 they are driven opposite to the T2 value
  task automatic test_cond_jump();
    logic [3:0]  ops   [4] = '{4'b0111, 4'b0111, 4'b1000, 4'b1000};
    logic        flagv [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [14:0] t2    [4] = '{15'h0, EI_|LP_, 15'h0, EI_|LP_};
    logic [14:0] exp_ctl [4];
    logic [2:0]  st [4] = '{3'd0, 3'd1, 3'd2, 3'd0};
    for (int k = 0; k < 4; k++) begin
      en = 1'b1;
      opcode = ops[k];
      exp_ctl = '{EP_|LM_, ER_|LI_|C_, t2[k], EP_|LM_};
      do_reset();
      for (int i = 0; i < 4; i++) begin
        carry_flag = (i == 2) ? flagv[k] : ~flagv[k];
        zero_flag  = (i == 2) ? flagv[k] : ~flagv[k];
        #1;
        total++;
        if (t_state !== st[i] || ctl !== exp_ctl[i])
          $display("FAIL jump%0d_cycle%0d: state=%0d ctl=%h required state=%0d ctl=%h",
                   k, i, t_state, ctl, st[i], exp_ctl[i]);
        else passed++;
        @(negedge clk);
      end
    end
    carry_flag = 1'b0;
    zero_flag = 1'b0;
  endtask

  // Single-step instructions and undefined codes: check T2 decode and the return to T0
  task automatic test_short_ops();
    logic [3:0]  ops [5] = '{4'b0101, 4'b0110, 4'b1110, 4'b0000, 4'b1010};
    logic [14:0] t2  [5] = '{EI_|LA_, EI_|LP_, EA_|LO_, 15'h0, 15'h0};
    for (int k = 0; k < 5; k++) begin
      en = 1'b1;
      opcode = ops[k];
      do_reset();
      @(negedge clk);
      @(negedge clk);
      #1;
      total++;
      if (t_state !== 3'd2 || ctl !== t2[k])
        $display("FAIL short_op%0d_t2: state=%0d ctl=%h required state=2 ctl=%h", k, t_state, ctl, t2[k]);
      else passed++;
      @(negedge clk);
      #1;
      total++;
      if (t_state !== 3'd0 || ctl !== (EP_|LM_))
        $display("FAIL short_op%0d_ret: state=%0d ctl=%h required state=0 ctl=%h", k, t_state, ctl, EP_|LM_);
      else passed++;
    end
  endtask

  task automatic test_halt();
    en = 1'b1;
    opcode = 4'b1111;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    total++;
    if (t_state !== 3'd2 || ctl !== 15'h0 || hlt !== 1'b0)
      $display("FAIL halt_t2: state=%0d ctl=%h hlt=%b required state=2 ctl=0000 hlt=0", t_state, ctl, hlt);
    else passed++;
    for (int i = 0; i < 22; i++) begin
      @(negedge clk);
      en = (i % 5 == 3) ? 1'b0 : 1'b1;
      opcode = 4'(i);
      #1;
      total++;
      if (t_state !== 3'd7 || ctl !== 15'h0 || hlt !== 1'b1)
        $display("FAIL halt_hold%0d: state=%0d ctl=%h hlt=%b required state=7 ctl=0000 hlt=1", i, t_state, ctl, hlt);
      else passed++;
    end
    en = 1'b1;
    #1;
    rst = 1'b0;
    #1;
    total++;
    if (t_state !== 3'd0 || hlt !== 1'b0 || ctl !== 15'h0)
      $display("FAIL halt_reset: state=%0d hlt=%b ctl=%h required state=0 hlt=0 ctl=0000", t_state, hlt, ctl);
    else passed++;
    rst = 1'b1;
  endtask

  task automatic test_en_freeze();
    opcode = 4'b0010;
    en = 1'b1;
    do_reset();
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if (t_state !== 3'd3 || ctl !== 15'h0 || hlt !== 1'b0)
        $display("FAIL freeze%0d: state=%0d ctl=%h hlt=%b required state=3 ctl=0000 hlt=0", i, t_state, ctl, hlt);
      else passed++;
      @(negedge clk);
    end
    en = 1'b1;
    #1;
    total++;
    if (t_state !== 3'd3 || ctl !== (ER_|LB_))
      $display("FAIL freeze_resume_t3: state=%0d ctl=%h required state=3 ctl=%h", t_state, ctl, ER_|LB_);
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if (t_state !== 3'd4 || ctl !== (EU_|LA_|FL_))
      $display("FAIL freeze_resume_t4: state=%0d ctl=%h required state=4 ctl=%h", t_state, ctl, EU_|LA_|FL_);
    else passed++;
    @(negedge clk);
    #1;
    total++;
    if (t_state !== 3'd0)
      $display("FAIL freeze_resume_t0: state=%0d required state=0", t_state);
    else passed++;
  endtask

  // Random stream: bus drivers never collide, no illegal state code, hlt tracks HALT, en=0 silences strobes
  task automatic test_random();
    logic [4:0] bus;
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      opcode = 4'($urandom_range(0, 15));
      carry_flag = 1'($urandom_range(0, 1));
      zero_flag = 1'($urandom_range(0, 1));
      en = ($urandom_range(0, 7) != 0);
      if (i % 250 == 249) begin
        rst = 1'b0;
        #1;
        rst = 1'b1;
      end
      #1;
      bus = {ep, er, ei, ea, eu};
      total++;
      if (!$onehot0(bus) || t_state == 3'd5 || t_state == 3'd6 || hlt !== (t_state == 3'd7) ||
          (!en && ctl !== 15'h0))
        $display("FAIL random%0d: bus=%b state=%0d hlt=%b en=%b ctl=%h required onehot0 bus, legal state, hlt=(state==7), ctl=0 when en=0",
                 i, bus, t_state, hlt, en, ctl);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_lda_sta();
    test_add_sub();
    test_cond_jump();
    test_short_ops();
    test_halt();
    test_en_freeze();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cpu_controller.md
CPU_CONTROLLER -- requirements
Module: cpu_controller

Interface
REQ-001 Ports SHALL be, one per line (name, direction, width, meaning):
- clk  in  1  single system clock; all state changes on rising edge.
- rst  in  1  asynchronous, active-low reset.
- en  in  1  run enable; 0 freezes sequencing.
- opcode  in  4  instruction-register opcode field; valid from T2 onward.
- carry_flag  in  1  latched carry from flags register.
- zero_flag  in  1  latched zero from flags register.
- c  out  1  PC count enable.
- ep  out  1  PC drives bus.
- lp  out  1  PC loads from bus.
- lm  out  1  MAR load.
- er  out  1  RAM drives bus.
- we  out  1  RAM write.
- li  out  1  IR load.
- ei  out  1  IR operand drives bus.
- la  out  1  A load.
- ea  out  1  A drives bus.
- lb  out  1  B load.
- eu  out  1  ALU drives bus.
- su  out  1  ALU subtract select.
- fl  out  1  flags register load.
- lo  out  1  output register load.
- hlt  out  1  halted indicator.
- t_state  out  3  current step: 0..4 = T0..T4, 7 = HALT.

Function
REQ-002 Opcodes SHALL be: 0000 NOP, 0001 LDA, 0010 ADD, 0011 SUB, 0100 STA, 0101 LDI, 0110 JMP, 0111 JC, 1000 JZ, 1110 OUT, 1111 HLT; all other codes execute as NOP.
REQ-003 States SHALL be T0, T1, T2, T3, T4, HALT.
REQ-004 Control outputs SHALL be combinational decodes of state, opcode and flags; every output not listed for a step is 0.
REQ-005 T0: ep, lm. T1: er, li, c. Both identical for every opcode.
REQ-006 NOP/undefined: T2 asserts nothing, then T0.
REQ-007 LDA: T2 ei, lm; T3 er, la; then T0.
REQ-008 ADD: T2 ei, lm; T3 er, lb; T4 eu, la, fl; then T0.
REQ-009 SUB: same as ADD, with su also asserted in T4.
REQ-010 STA: T2 ei, lm; T3 ea, we; then T0.
REQ-011 LDI: T2 ei, la; then T0.
REQ-012 JMP: T2 ei, lp; then T0.
REQ-013 JC: in T2, ei, lp only if carry_flag=1, else nothing; then T0. JZ: same, gated by zero_flag.
REQ-014 OUT: T2 ea, lo; then T0.
REQ-015 HLT: T2 asserts nothing, then HALT; HALT asserts only hlt=1 and remains until reset.
REQ-016 Transitions: T0->T1->T2 unconditionally; after an instruction's last step, next state is T0 (early termination, no idle steps).
REQ-017 At most one of ep, er, ei, ea, eu SHALL be 1 in any cycle.
REQ-018 en=0: state held, all control outputs 0, t_state still reports the held state; hlt unaffected by en. Sequencing resumes from the held state on the first edge with en=1.
REQ-019 Flags SHALL be sampled combinationally during T2 only; flag changes in other steps have no effect.
REQ-020 t_state SHALL be registered state encoding; never reports 5 or 6.

Reset
REQ-021 rst=0 SHALL immediately force state T0 (t_state=0) and all control outputs and hlt to 0, independent of clk.
REQ-022 On rst release, the first rising edge with en=1 executes T0 (ep, lm) then advances to T1; reset mid-instruction or in HALT abandons it with no partial outputs.

Verification
REQ-023 Reset then en=1, opcode=0001 -> cycles show T0 {ep,lm}, T1 {er,li,c}, T2 {ei,lm}, T3 {er,la}, then t_state=0.
REQ-024 opcode=0011 -> T4 shows eu=su=la=fl=1; total 5 cycles per instruction; next cycle t_state=0.
REQ-025 opcode=0111 with carry_flag=0 -> T2 lp=0, ei=0; repeat with carry_flag=1 -> T2 lp=1, ei=1; both return to T0 after 3 cycles.
REQ-026 opcode=1111 -> after T2, t_state=7, hlt=1, all others 0 for 20+ cycles; pulse rst low -> t_state=0, hlt=0 immediately.
REQ-027 en dropped to 0 during T3 of ADD for 4 cycles -> outputs 0, t_state=3 held; en=1 -> T3 {er,lb} then T4 completes.
REQ-028 Random opcode/flag/en stream, 10k cycles -> bus-driver one-hot-or-zero (REQ-017) never violated; t_state never 5 or 6.
